execute_completion_buffer: RTL

Parametrised in-order completion buffer for the execute stage's multicycle units (divider, carry-less multiplier, FPU). Today the execute stage stalls until a unit's `ready` rises. This block instead lets up to DEPTH multicycle operations be outstanding at once. Units return results out of order, tagged; the block retires them strictly in issue order to the integer or FP register write port, with fflags. It sits between execute-stage issue logic and `register_win` / `fp_register_win`, and supplies a RAW hazard query for the decode/forwarding logic.

---
 rtl/execute_completion_buffer_if.sv | 56 +++++
 rtl/execute_completion_buffer.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/execute_completion_buffer_if.sv
// Bundle of the issue, completion, writeback and hazard-query signals of the
// execute-stage completion buffer. "master" is the issue/unit side and
// "slave" is the buffer itself.
interface execute_completion_buffer_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4,
  parameter int UNITS = 3,
  parameter int TAGW  = $clog2(DEPTH),
  parameter int UW    = (UNITS > 1) ? $clog2(UNITS) : 1
);
  logic                    issue_valid;
  logic                    issue_ready;
  logic [UW-1:0]           issue_unit;
  logic [4:0]              issue_waddr;
  logic                    issue_fp;
  logic                    issue_fflags;
  logic [TAGW-1:0]         issue_tag;
  logic [UNITS-1:0]        unit_en;
  logic [UNITS-1:0]        done_valid;
  logic [UNITS*TAGW-1:0]   done_tag;
  logic [UNITS*XLEN-1:0]   done_result;
  logic [UNITS*5-1:0]      done_flags;
  logic                    clear;
  logic                    win_wren;
  logic [4:0]              win_waddr;
  logic [XLEN-1:0]         win_wdata;
  logic                    fwin_wren;
  logic [4:0]              fwin_waddr;
  logic [XLEN-1:0]         fwin_wdata;
  logic                    fflags_valid;
  logic [4:0]              fflags;
  logic [4:0]              query_addr1;
  logic [4:0]              query_addr2;
  logic                    query_fp;
  logic                    query_hit;
  logic                    busy;
  logic [TAGW:0]           count;

  modport master (
    output issue_valid, issue_unit, issue_waddr, issue_fp, issue_fflags,
    output done_valid, done_tag, done_result, done_flags, clear,
    output query_addr1, query_addr2, query_fp,
    input  issue_ready, issue_tag, unit_en,
    input  win_wren, win_waddr, win_wdata, fwin_wren, fwin_waddr, fwin_wdata,
    input  fflags_valid, fflags, query_hit, busy, count
  );

  modport slave (
    input  issue_valid, issue_unit, issue_waddr, issue_fp, issue_fflags,
    input  done_valid, done_tag, done_result, done_flags, clear,
    input  query_addr1, query_addr2, query_fp,
    output issue_ready, issue_tag, unit_en,
    output win_wren, win_waddr, win_wdata, fwin_wren, fwin_waddr, fwin_wdata,
    output fflags_valid, fflags, query_hit, busy, count
  );
endinterface

// File: rtl/execute_completion_buffer.sv
// In-order completion buffer for the execute stage's multicycle units.
// Operations are allocated in issue order, complete out of order by tag and
// retire strictly from the head to the integer or FP register write port.
module execute_completion_buffer #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4,
  parameter int UNITS = 3,
  parameter int TAGW  = $clog2(DEPTH),
  parameter int UW    = (UNITS > 1) ? $clog2(UNITS) : 1
) (
  input logic                      clock,
  input logic                      reset,
  execute_completion_buffer_if.slave bus
);
  localparam logic [TAGW:0] FULL_CNT = (TAGW+1)'(DEPTH);
  localparam logic [UW:0]   UNIT_LIM = (UW+1)'(UNITS);

  logic [DEPTH-1:0] valid_q, valid_d, done_q, done_d;
  logic [DEPTH-1:0] fp_q, fp_d, fen_q, fen_d;
  logic [4:0]       waddr_q [DEPTH];
  logic [4:0]       waddr_d [DEPTH];
  logic [XLEN-1:0]  data_q  [DEPTH];
  logic [XLEN-1:0]  data_d  [DEPTH];
  logic [4:0]       flags_q [DEPTH];
  logic [4:0]       flags_d [DEPTH];
  logic [TAGW-1:0]  head_q, head_d, tail_q, tail_d;
  logic [TAGW:0]    count_q, count_d;

  logic             ready_s, accept_s, retire_s, hit_s;
  logic [UNITS-1:0] unit_en_s;

  // Handshake: accept only with room, a real unit, no flush and reset released.
  always_comb begin
    ready_s  = (count_q != FULL_CNT);
    accept_s = bus.issue_valid & ready_s & ({1'b0, bus.issue_unit} < UNIT_LIM)
               & ~bus.clear & reset;
    retire_s = valid_q[head_q] & done_q[head_q] & ~bus.clear;
    for (int u = 0; u < UNITS; u++) begin
      unit_en_s[u] = accept_s & (bus.issue_unit == UW'(u));
    end
  end

  // Next entry state: completions, then head retire, then tail allocation.
  always_comb begin
    valid_d = valid_q;
    done_d  = done_q;
    fp_d    = fp_q;
    fen_d   = fen_q;
    waddr_d = waddr_q;
    data_d  = data_q;
    flags_d = flags_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (bus.clear) begin
      valid_d = '0;
      done_d  = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      // Highest unit first so that the lowest matching unit is written last and wins.
      for (int i = 0; i < DEPTH; i++) begin
        for (int u = UNITS - 1; u >= 0; u--) begin
          if (bus.done_valid[u] && valid_q[i] &&
              (bus.done_tag[u*TAGW +: TAGW] == TAGW'(i))) begin
            done_d[i]  = 1'b1;
            data_d[i]  = bus.done_result[u*XLEN +: XLEN];
            flags_d[i] = bus.done_flags[u*5 +: 5];
          end else begin
            done_d[i]  = done_d[i];
          end
        end
      end
      if (retire_s) begin
        valid_d[head_q] = 1'b0;
        done_d[head_q]  = 1'b0;
        head_d          = head_q + 1'b1;
      end else begin
        head_d          = head_q;
      end
      // Tail is never the retiring head: a full buffer refuses issue.
      if (accept_s) begin
        valid_d[tail_q] = 1'b1;
        done_d[tail_q]  = 1'b0;
        fp_d[tail_q]    = bus.issue_fp;
        fen_d[tail_q]   = bus.issue_fflags;
        waddr_d[tail_q] = bus.issue_waddr;
        tail_d          = tail_q + 1'b1;
      end else begin
        tail_d          = tail_q;
      end
      case ({accept_s, retire_s})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // RAW hazard query: any uncommitted writer of a source register; x0 is never a hazard.
  always_comb begin
    hit_s = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      hit_s = hit_s | (valid_q[i] & (fp_q[i] == bus.query_fp)
                       & ((waddr_q[i] == bus.query_addr1) | (waddr_q[i] == bus.query_addr2))
                       & (fp_q[i] | (waddr_q[i] != 5'd0)));
    end
  end

  // Writeback port drive from the head entry; a flush silences everything.
  always_comb begin
    bus.win_wren     = retire_s & ~fp_q[head_q] & (waddr_q[head_q] != 5'd0);
    bus.fwin_wren    = retire_s & fp_q[head_q];
    bus.fflags_valid = retire_s & fen_q[head_q];
    if (bus.clear) begin
      bus.win_waddr  = 5'd0;
      bus.win_wdata  = '0;
      bus.fwin_waddr = 5'd0;
      bus.fwin_wdata = '0;
      bus.fflags     = 5'd0;
    end else begin
      bus.win_waddr  = waddr_q[head_q];
      bus.win_wdata  = data_q[head_q];
      bus.fwin_waddr = waddr_q[head_q];
      bus.fwin_wdata = data_q[head_q];
      bus.fflags     = flags_q[head_q];
    end
  end

  assign bus.issue_ready = ready_s;
  assign bus.issue_tag   = tail_q;
  assign bus.unit_en     = unit_en_s;
  assign bus.query_hit   = hit_s;
  assign bus.busy        = (count_q != '0);
  assign bus.count       = count_q;

  // State registers; reset drops every entry immediately.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
      done_q  <= '0;
      fp_q    <= '0;
      fen_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        waddr_q[i] <= 5'd0;
        data_q[i]  <= '0;
        flags_q[i] <= 5'd0;
      end
    end else begin
      valid_q <= valid_d;
      done_q  <= done_d;
      fp_q    <= fp_d;
      fen_q   <= fen_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      waddr_q <= waddr_d;
      data_q  <= data_d;
      flags_q <= flags_d;
    end
  end
endmodule
